// File: rtl/uart_rx_controller.sv
// UART receive sequencer: oversampled start validation, LSB-first data shift,
// optional parity, one or two stop bits, and RX FIFO push with sticky error flags.
module uart_rx_controller #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_sample_en,
    input  logic       rx,
    input  logic       parity_en,
    input  logic       parity_odd,
    input  logic       double_stop_bit,
    input  logic       rx_queue_full,
    input  logic       err_clear,
    output logic       rx_queue_we,
    output logic [7:0] rx_data,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy,
    output logic [2:0] fsm_state
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] CNT_LAST    = SW'(OVERSAMPLE - 1);
    // START compares the pre-increment count, so mid-bit lands on tick OVERSAMPLE/2-1.
    localparam logic [SW-1:0] CNT_MID_PRE = SW'(OVERSAMPLE / 2 - 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t      state, state_next;
    logic        rx_meta, rx_s, rx_prev;
    logic [SW-1:0] sample_cnt, sample_cnt_next;
    logic [2:0]  bit_cnt, bit_cnt_next;
    logic [7:0]  shift_reg, shift_next;
    logic        cfg_parity_en, cfg_parity_en_next;
    logic        cfg_parity_odd, cfg_parity_odd_next;
    logic        cfg_double_stop, cfg_double_stop_next;
    logic        par_mismatch, par_mismatch_next;
    logic        stop_bad, stop_bad_next;
    logic        frame_end, end_bad;
    logic        push, set_parity, set_frame, set_overrun;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta         <= 1'b1;
            rx_s            <= 1'b1;
            rx_prev         <= 1'b1;
            state           <= IDLE;
            sample_cnt      <= '0;
            bit_cnt         <= '0;
            shift_reg       <= '0;
            cfg_parity_en   <= 1'b0;
            cfg_parity_odd  <= 1'b0;
            cfg_double_stop <= 1'b0;
            par_mismatch    <= 1'b0;
            stop_bad        <= 1'b0;
            rx_queue_we     <= 1'b0;
            rx_data         <= '0;
            parity_err      <= 1'b0;
            frame_err       <= 1'b0;
            overrun_err     <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            if (rx_sample_en) rx_prev <= rx_s;
            state           <= state_next;
            sample_cnt      <= sample_cnt_next;
            bit_cnt         <= bit_cnt_next;
            shift_reg       <= shift_next;
            cfg_parity_en   <= cfg_parity_en_next;
            cfg_parity_odd  <= cfg_parity_odd_next;
            cfg_double_stop <= cfg_double_stop_next;
            par_mismatch    <= par_mismatch_next;
            stop_bad        <= stop_bad_next;
            rx_queue_we     <= push;
            if (push) rx_data <= shift_reg;
            // A flag being set this cycle takes priority over err_clear.
            parity_err  <= set_parity  | (parity_err  & ~err_clear);
            frame_err   <= set_frame   | (frame_err   & ~err_clear);
            overrun_err <= set_overrun | (overrun_err & ~err_clear);
        end
    end

    always_comb begin
        state_next           = state;
        sample_cnt_next      = sample_cnt;
        bit_cnt_next         = bit_cnt;
        shift_next           = shift_reg;
        cfg_parity_en_next   = cfg_parity_en;
        cfg_parity_odd_next  = cfg_parity_odd;
        cfg_double_stop_next = cfg_double_stop;
        par_mismatch_next    = par_mismatch;
        stop_bad_next        = stop_bad;
        frame_end            = 1'b0;
        end_bad              = 1'b0;
        push                 = 1'b0;
        set_parity           = 1'b0;
        set_frame            = 1'b0;
        set_overrun          = 1'b0;

        if (rx_sample_en) begin
            case (state)
                IDLE: begin
                    if (!rx_s && rx_prev) begin
                        sample_cnt_next = '0;
                        state_next      = START;
                    end
                end
                START: begin
                    sample_cnt_next = sample_cnt + 1'b1;
                    if (sample_cnt == CNT_MID_PRE) begin
                        if (rx_s) begin
                            state_next = IDLE;
                        end else begin
                            cfg_parity_en_next   = parity_en;
                            cfg_parity_odd_next  = parity_odd;
                            cfg_double_stop_next = double_stop_bit;
                            par_mismatch_next    = 1'b0;
                            stop_bad_next        = 1'b0;
                            sample_cnt_next      = '0;
                            bit_cnt_next         = '0;
                            state_next           = DATA;
                        end
                    end
                end
                default: begin
                    sample_cnt_next = sample_cnt + 1'b1;
                    if (sample_cnt == CNT_LAST) begin
                        sample_cnt_next = '0;
                        case (state)
                            DATA: begin
                                shift_next   = {rx_s, shift_reg[7:1]};
                                bit_cnt_next = bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7)
                                    state_next = cfg_parity_en ? PARITY : STOP1;
                            end
                            PARITY: begin
                                par_mismatch_next = ((^shift_reg) ^ rx_s) != cfg_parity_odd;
                                state_next        = STOP1;
                            end
                            STOP1: begin
                                if (cfg_double_stop) begin
                                    stop_bad_next = !rx_s;
                                    state_next    = STOP2;
                                end else begin
                                    frame_end = 1'b1;
                                    end_bad   = !rx_s;
                                end
                            end
                            default: begin
                                frame_end = 1'b1;
                                end_bad   = stop_bad || !rx_s;
                            end
                        endcase
                    end
                end
            endcase
        end

        if (frame_end) begin
            state_next = IDLE;
            if (end_bad) begin
                set_frame = 1'b1;
            end else if (rx_queue_full) begin
                set_overrun = 1'b1;
            end else begin
                push       = 1'b1;
                set_parity = par_mismatch;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule
